// File: rtl/matrix_10x10_pkg.sv
// Shared geometry and entry type for the 10x10 matrix store
// and the multiplier datapath that uses it.
package matrix_10x10_pkg;

  localparam int MAT_ROWS   = 10;
  localparam int MAT_COLS   = 10;
  localparam int MAT_ADDR_W = 4;
  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] mat_entry_t;

endpackage

// File: rtl/matrix_10x10_row.sv
// One matrix row: MAT_COLS entries with a column write decode.
// Entries are exported flat so the top can build its read mux.
module matrix_10x10_row
  import matrix_10x10_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [MAT_ADDR_W-1:0]          col_addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [MAT_COLS*DATA_WIDTH-1:0] row_data
);

  logic [DATA_WIDTH-1:0] mem_q [MAT_COLS];
  logic [DATA_WIDTH-1:0] mem_d [MAT_COLS];

  // Columns 10..15 match no entry, so they write nothing.
  always_comb begin
    mem_d = mem_q;
    for (int c = 0; c < MAT_COLS; c++) begin
      if (rst) begin
        mem_d[c] = '0;
      end else if (we && col_addr == MAT_ADDR_W'(c)) begin
        mem_d[c] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < MAT_COLS; c++) begin
      row_data[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[c];
    end
  end

endmodule

// File: rtl/matrix_10x10.sv
// 10x10 operand/result store: one write per clock,
// combinational read that returns 0 when disabled or out of range.
module matrix_10x10
  import matrix_10x10_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_ReadMat,
  input  logic                  en_WriteMat,
  input  logic [MAT_ADDR_W-1:0] rowAddr,
  input  logic [MAT_ADDR_W-1:0] colAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  logic [MAT_COLS*DATA_WIDTH-1:0] row_data [MAT_ROWS];
  logic [MAT_ROWS-1:0]            row_we;

  for (genvar r = 0; r < MAT_ROWS; r++) begin : g_row
    assign row_we[r] = en_WriteMat && (rowAddr == MAT_ADDR_W'(r));

    matrix_10x10_row #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_row (
      .clk      (clk),
      .rst      (rst),
      .we       (row_we[r]),
      .col_addr (colAddr),
      .wdata    (writeData),
      .row_data (row_data[r])
    );
  end

  // Exact row/col match only: addresses 10..15 fall through to 0.
  always_comb begin
    readData = '0;
    if (en_ReadMat) begin
      for (int r = 0; r < MAT_ROWS; r++) begin
        for (int c = 0; c < MAT_COLS; c++) begin
          if (rowAddr == MAT_ADDR_W'(r) && colAddr == MAT_ADDR_W'(c)) begin
            readData = row_data[r][c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_10x10.sv
// Directed bench for matrix_10x10: reference array plus a queue of
// expected read values pushed at stimulus time and popped at sampling.
module tb_matrix_10x10;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_ReadMat;
  logic       en_WriteMat;
  logic [3:0] rowAddr;
  logic [3:0] colAddr;
  logic [7:0] writeData;
  logic [7:0] readData;

  logic [7:0] model [10][10];
  logic [7:0] sb [$];
  int         errors = 0;
  int         checks = 0;

  matrix_10x10 #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_ReadMat  (en_ReadMat),
    .en_WriteMat (en_WriteMat),
    .rowAddr     (rowAddr),
    .colAddr     (colAddr),
    .writeData   (writeData),
    .readData    (readData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        model[r][c] = 8'h00;
  endtask

  task automatic do_write(input int r, input int c, input logic [7:0] d);
    @(negedge clk);
    rowAddr     = 4'(r);
    colAddr     = 4'(c);
    writeData   = d;
    en_WriteMat = 1'b1;
    en_ReadMat  = 1'b0;
    @(posedge clk);
    #1;
    en_WriteMat = 1'b0;
    if (r < 10 && c < 10) model[r][c] = d;
  endtask

  task automatic do_read(input int r, input int c, input logic ren,
                         input string tag);
    logic [7:0] got_exp;
    @(negedge clk);
    rowAddr    = 4'(r);
    colAddr    = 4'(c);
    en_ReadMat = ren;
    if (ren && r < 10 && c < 10) sb.push_back(model[r][c]);
    else sb.push_back(8'h00);
    #1;
    got_exp = sb.pop_front();
    check($sformatf("%s[%0d,%0d]", tag, r, c), readData, got_exp);
    en_ReadMat = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        do_read(r, c, 1'b1, tag);
  endtask

  initial begin
    rst         = 1'b0;
    en_ReadMat  = 1'b0;
    en_WriteMat = 1'b0;
    rowAddr     = '0;
    colAddr     = '0;
    writeData   = '0;

    // Reset for one edge
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    read_all("reset");

    // Row-major random fill
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        do_write(r, c, 8'($urandom_range(0, 255)));
    read_all("fill");

    // Single overwrite and neighbours
    do_write(3, 3, 8'd100);
    do_read(3, 3, 1'b1, "ovw");
    do_read(3, 2, 1'b1, "ovw_left");
    do_read(3, 4, 1'b1, "ovw_right");

    // Out-of-range writes must not alias
    do_write(10, 5, 8'hAA);
    do_write(2, 12, 8'hAB);
    do_write(15, 15, 8'hAC);
    read_all("oor_keep");
    do_read(10, 5, 1'b1, "oor_rd");
    do_read(5, 10, 1'b1, "oor_rd");
    do_read(15, 0, 1'b1, "oor_rd");

    // Read disabled
    do_read(0, 0, 1'b0, "rd_off");
    do_read(9, 9, 1'b0, "rd_off");
    do_read(3, 3, 1'b0, "rd_off");

    // Simultaneous read and write, no bypass
    do_write(4, 5, 8'd7);
    @(negedge clk);
    rowAddr     = 4'd4;
    colAddr     = 4'd5;
    writeData   = 8'd9;
    en_ReadMat  = 1'b1;
    en_WriteMat = 1'b1;
    sb.push_back(8'd7);
    #1;
    check("simul_before", readData, sb.pop_front());
    sb.push_back(8'd9);
    @(posedge clk);
    #1;
    check("simul_after", readData, sb.pop_front());
    en_WriteMat = 1'b0;
    en_ReadMat  = 1'b0;
    model[4][5] = 8'd9;
    do_read(4, 5, 1'b1, "simul_hold");

    // Reset beats a same-cycle write and wipes the fill
    @(negedge clk);
    rst         = 1'b1;
    en_WriteMat = 1'b1;
    rowAddr     = 4'd0;
    colAddr     = 4'd0;
    writeData   = 8'd55;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    en_WriteMat = 1'b0;
    model_clear();
    do_read(0, 0, 1'b1, "rst_prio");
    read_all("rst_mid");

    // Write still works after reset
    do_write(9, 9, 8'h5A);
    do_read(9, 9, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
